// File: rtl/muxbus_responder_pkg.sv
// -----------------------------------------------------------------------------
// muxbus_responder_pkg
// Shared definitions for the multiplexed-bus memory responder:
//   - state_t   : responder bus-cycle state machine encoding
//   - OE_WRITE / OE_READ : values of the core's uio_oe that mark a write / read
//   - in_window : address-window hit test used by the responder
// -----------------------------------------------------------------------------
package muxbus_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam logic [7:0] OE_WRITE = 8'hFF;
  localparam logic [7:0] OE_READ  = 8'h00;

  // True when addr falls in the 2^aw-byte window starting at base.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int unsigned aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/muxbus_responder_if.sv
// -----------------------------------------------------------------------------
// muxbus_responder_if
// Signals between the 6502 core's multiplexed external bus and its memory
// responder.
//   phi        : bus phase (core clk_cpu); high = addr_mux carries ab[15:8]
//   addr_mux   : core uo_out, time-shared address byte
//   bus_in     : core uio_out, write data while phi is high
//   bus_oe_in  : core uio_oe, 8'hFF write / 8'h00 read
//   data_out   : read data returned to the core
//   data_oe    : drive enable for data_out
//   phase_err  : sticky protocol-violation flag
//   rd_count   : completed read cycles (zero unless stats are built in)
//   wr_count   : completed write cycles (zero unless stats are built in)
// Modports: master = core side, slave = responder side.
// -----------------------------------------------------------------------------
interface muxbus_responder_if;
  logic        phi;
  logic [7:0]  addr_mux;
  logic [7:0]  bus_in;
  logic [7:0]  bus_oe_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        phase_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  modport master (
    output phi, addr_mux, bus_in, bus_oe_in,
    input  data_out, data_oe, phase_err, rd_count, wr_count
  );

  modport slave (
    input  phi, addr_mux, bus_in, bus_oe_in,
    output data_out, data_oe, phase_err, rd_count, wr_count
  );
endinterface

// File: rtl/muxbus_ram.sv
// -----------------------------------------------------------------------------
// muxbus_ram
// Synchronous single-port byte RAM, depth 2^AW, registered read.
//   clk   : clock
//   addr  : byte index
//   we    : write enable (wdata written at addr on the clock edge)
//   wdata : write data
//   rdata : registered read data (old contents on a same-edge write)
// -----------------------------------------------------------------------------
module muxbus_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // NOTE: the array has no reset branch; memories keep their contents across
  // reset, and a reset loop would stop the tools mapping this onto a RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/muxbus_responder.sv
// -----------------------------------------------------------------------------
// muxbus_responder
// Memory-side responder for the 6502 core's multiplexed external bus.
// Rebuilds the 16-bit address from the two address phases, serves reads from
// an internal byte RAM and commits writes on the falling edge of phi.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : muxbus_responder_if.slave (see interface header)
// Parameters: MEM_AW (log2 RAM bytes), BASE (window base), MISS_DATA (byte
// returned for reads outside the window).
// Optional macro MUXBUS_RESP_STATS_EN: builds the read/write cycle counters;
// without it rd_count/wr_count are tied to zero.
// -----------------------------------------------------------------------------
module muxbus_responder
  import muxbus_responder_pkg::*;
#(
  parameter int         MEM_AW    = 8,
  parameter logic [15:0] BASE     = 16'h0000,
  parameter logic [7:0] MISS_DATA = 8'hEA
) (
  input logic             clk,
  input logic             rst_n,
  muxbus_responder_if.slave bus
);

  state_t            state_q, state_d;
  logic              phi_q, fall, rise;
  logic              lo_done_q, is_wr_q, hit_q, phase_err_q;
  logic [7:0]        addr_lo_q, addr_hi_q, wdata_q, data_out_q, ram_rdata;
  logic              latch_lo, latch_hi, cycle_done, err_set, ram_we;
  logic [MEM_AW-1:0] ram_idx;

  assign fall = phi_q & ~bus.phi;
  assign rise = ~phi_q & bus.phi;

  // In S_HI the high byte is still on the pins, so the read is issued from
  // them directly; afterwards the latched copy addresses the write.
  assign ram_idx = (state_q == S_HI) ? MEM_AW'({bus.addr_mux, addr_lo_q})
                                     : MEM_AW'({addr_hi_q, addr_lo_q});
  assign ram_we  = cycle_done & is_wr_q & hit_q;

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    latch_lo   = 1'b0;
    latch_hi   = 1'b0;
    cycle_done = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE: if (fall) state_d = S_LO;
      S_LO: begin
        if (rise) begin
          if (!lo_done_q) begin
            // Low phase too short to have sampled the low address byte.
            err_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_HI;
          end
        end else if (!lo_done_q) begin
          latch_lo = 1'b1;
        end
      end
      S_HI: begin
        if (fall) begin
          // High phase too short: abandon the cycle, the fall opens the next.
          err_set = 1'b1;
          state_d = S_LO;
        end else begin
          latch_hi = 1'b1;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          cycle_done = 1'b1;
          state_d    = S_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phi_q       <= 1'b0;
      lo_done_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      hit_q       <= 1'b0;
      addr_lo_q   <= '0;
      addr_hi_q   <= '0;
      wdata_q     <= '0;
      data_out_q  <= '0;
      phase_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phi_q   <= bus.phi;
      if (latch_lo) begin
        addr_lo_q <= bus.addr_mux;
        is_wr_q   <= (bus.bus_oe_in == OE_WRITE);
        lo_done_q <= 1'b1;
      end else if (state_q != S_LO) begin
        lo_done_q <= 1'b0;
      end
      if (latch_hi) begin
        addr_hi_q <= bus.addr_mux;
        wdata_q   <= bus.bus_in;
        hit_q     <= in_window({bus.addr_mux, addr_lo_q}, BASE, MEM_AW);
      end
      if (state_q == S_DATA) data_out_q <= hit_q ? ram_rdata : MISS_DATA;
      if (err_set) phase_err_q <= 1'b1;
    end
  end

  muxbus_ram #(.AW(MEM_AW)) u_ram (
    .clk   (clk),
    .addr  (ram_idx),
    .we    (ram_we),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.data_out  = data_out_q;
  // Combinational so the driver lets go in the same cycle phi drops.
  assign bus.data_oe   = (state_q == S_DATA) & ~is_wr_q & bus.phi;
  assign bus.phase_err = phase_err_q;

`ifdef MUXBUS_RESP_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (cycle_done) begin
      if (is_wr_q) wr_cnt_q <= wr_cnt_q + 16'd1;
      else         rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign bus.rd_count = rd_cnt_q;
  assign bus.wr_count = wr_cnt_q;
`else
  assign bus.rd_count = '0;
  assign bus.wr_count = '0;
`endif

endmodule

// File: tb/tb_muxbus_responder.sv
// -----------------------------------------------------------------------------
// tb_muxbus_responder
// Directed bench for muxbus_responder: plays the 6502 side of the multiplexed
// bus cycle by cycle and compares responder outputs with hand-derived values.
// Inputs change on the falling clk edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_muxbus_responder;
  import muxbus_responder_pkg::*;

`ifdef MUXBUS_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rd_pending = 1'b0;

  muxbus_responder_if bus ();

  muxbus_responder #(
    .MEM_AW    (8),
    .BASE      (16'h0000),
    .MISS_DATA (8'hEA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One core bus cycle, starting on a falling clk edge with phi high and
  // ending on a falling clk edge with phi still high. The cycle completes
  // (commit/count) on the fall that starts the following call.
  task automatic bus_cycle(input logic [15:0] a, input bit wr, input logic [7:0] wd,
                           input int lo_len, input int hi_len, input bit chk,
                           input logic [7:0] exp_rd, input string tag);
    bus.phi       = 1'b0;
    bus.addr_mux  = a[7:0];
    bus.bus_oe_in = wr ? OE_WRITE : OE_READ;
    bus.bus_in    = 8'h00;
    #1;
    if (rd_pending) check("oe_release", 32'(bus.data_oe), 32'h0);
    rd_pending = 1'b0;
    repeat (lo_len) @(negedge clk);
    bus.phi      = 1'b1;
    bus.addr_mux = a[15:8];
    bus.bus_in   = wd;
    for (int i = 1; i <= hi_len; i++) begin
      @(negedge clk);
      if (i == 3 && chk) begin
        check({tag, "_data"}, 32'(bus.data_out), 32'(exp_rd));
        check({tag, "_oe"},   32'(bus.data_oe),  32'h1);
        rd_pending = 1'b1;
      end
    end
  endtask

  task automatic check_counts(input string tag, input logic [15:0] rd, input logic [15:0] wr);
    check({tag, "_rd_count"}, 32'(bus.rd_count), STATS ? 32'(rd) : 32'h0);
    check({tag, "_wr_count"}, 32'(bus.wr_count), STATS ? 32'(wr) : 32'h0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    rd_pending = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.phi       = 1'b1;
    bus.addr_mux  = 8'h00;
    bus.bus_in    = 8'h00;
    bus.bus_oe_in = OE_READ;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data_out",  32'(bus.data_out),  32'h0);
    check("rst_data_oe",   32'(bus.data_oe),   32'h0);
    check("rst_phase_err", 32'(bus.phase_err), 32'h0);
    check("rst_state",     32'(dut.state_q),   32'(S_IDLE));
    check_counts("rst", 16'h0, 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Rise on the first clk of S_LO: error, back to idle
    bus_cycle(16'h0000, 1'b0, 8'h00, 1, 4, 1'b0, 8'h00, "lo_err");
    check("lo_err_flag",  32'(bus.phase_err), 32'h1);
    check("lo_err_state", 32'(dut.state_q),   32'(S_IDLE));
    check("lo_err_oe",    32'(bus.data_oe),   32'h0);
    pulse_reset();
    check("rst_clears_err", 32'(bus.phase_err), 32'h0);

    // Normal traffic
    bus_cycle(16'h0012, 1'b1, 8'hA9, 2, 4, 1'b0, 8'h00, "w12");
    bus_cycle(16'h0000, 1'b1, 8'h3C, 2, 4, 1'b0, 8'h00, "w00");
    bus_cycle(16'h0041, 1'b1, 8'h99, 2, 4, 1'b0, 8'h00, "w41");
    bus_cycle(16'h0012, 1'b0, 8'h00, 2, 4, 1'b1, 8'hA9, "r12");
    bus_cycle(16'h0040, 1'b1, 8'h5C, 2, 4, 1'b0, 8'h00, "w40");
    bus_cycle(16'h0040, 1'b0, 8'h00, 3, 5, 1'b1, 8'h5C, "r40");
    bus_cycle(16'h8000, 1'b0, 8'h00, 2, 4, 1'b1, 8'hEA, "r8000_miss");
    bus_cycle(16'h8000, 1'b1, 8'h77, 2, 4, 1'b0, 8'h00, "w8000_miss");
    bus_cycle(16'h0000, 1'b0, 8'h00, 2, 4, 1'b1, 8'h3C, "r00_kept");
    check_counts("traffic", 16'd3, 16'd5);
    bus_cycle(16'h0041, 1'b0, 8'h00, 2, 4, 1'b1, 8'h99, "r41");
    check("no_err", 32'(bus.phase_err), 32'h0);

    // Reset in S_DATA of a read: drive enable drops at once
    bus_cycle(16'h0012, 1'b0, 8'h00, 2, 4, 1'b1, 8'hA9, "r12_pre_rst");
    check("oe_before_rst", 32'(bus.data_oe), 32'h1);
    rst_n = 1'b0;
    #1;
    check("oe_async_drop", 32'(bus.data_oe), 32'h0);
    rd_pending = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in S_DATA of a write: write discarded
    bus_cycle(16'h0041, 1'b1, 8'h33, 2, 4, 1'b0, 8'h00, "w41_rst");
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", 32'(dut.state_q), 32'(S_IDLE));
    check("rst_mid_oe",    32'(bus.data_oe), 32'h0);
    check_counts("rst_mid", 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_cycle(16'h0041, 1'b0, 8'h00, 2, 4, 1'b1, 8'h99, "r41_after_rst");

    // High phase too short during a write: dropped, flagged
    bus_cycle(16'h0012, 1'b1, 8'h55, 2, 1, 1'b0, 8'h00, "w12_short");
    bus_cycle(16'h0012, 1'b0, 8'h00, 2, 4, 1'b1, 8'hA9, "r12_after_short");
    check("hi_err_flag", 32'(bus.phase_err), 32'h1);
    check_counts("short", 16'd1, 16'd0);
    bus_cycle(16'h0040, 1'b0, 8'h00, 2, 4, 1'b1, 8'h5C, "r40_after_short");
    check_counts("post_short", 16'd2, 16'd0);

    // Read counter wrap
`ifdef MUXBUS_RESP_STATS_EN
    dut.rd_cnt_q = 16'hFFFE;
`endif
    bus_cycle(16'h0000, 1'b0, 8'h00, 2, 4, 1'b1, 8'h3C, "r00_wrap");
    check_counts("wrap_ffff", 16'hFFFF, 16'd0);
    bus_cycle(16'h0012, 1'b0, 8'h00, 2, 4, 1'b1, 8'hA9, "r12_wrap");
    check_counts("wrap_zero", 16'h0000, 16'd0);
    check("err_sticky", 32'(bus.phase_err), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
